// File: rtl/store_bypass_queue_pkg.sv
// Shared types and constants for the store bypass queue and its byte merge unit.
package store_bypass_queue_pkg;

  localparam int unsigned CACHE_LINE_BYTES   = 64;
  localparam int unsigned CACHE_LINE_BITS    = 512;
  localparam int unsigned STRAND_INDEX_WIDTH = 2;
  // Entries hold addresses zero-extended to this width so one typedef fits any ADDR_WIDTH.
  localparam int unsigned ADDR_WIDTH_MAX     = 64;

  typedef struct packed {
    logic                          valid;
    logic [STRAND_INDEX_WIDTH-1:0] strand;
    logic [ADDR_WIDTH_MAX-1:0]     addr;
    logic [CACHE_LINE_BITS-1:0]    data;
    logic [CACHE_LINE_BYTES-1:0]   mask;
  } store_entry_t;

  // Per byte, take new_line where sel is set, otherwise keep old_line.
  function automatic logic [CACHE_LINE_BITS-1:0] byte_select(
    input logic [CACHE_LINE_BYTES-1:0] sel,
    input logic [CACHE_LINE_BITS-1:0]  old_line,
    input logic [CACHE_LINE_BITS-1:0]  new_line
  );
    logic [CACHE_LINE_BITS-1:0] r;
    r = old_line;
    for (int b = 0; b < int'(CACHE_LINE_BYTES); b++) begin
      if (sel[b]) r[b*8 +: 8] = new_line[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/store_byte_merge.sv
// Byte-granular store combining and youngest-wins bypass selection across queue entries.
module store_byte_merge
  import store_bypass_queue_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 4,
  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic [CACHE_LINE_BITS-1:0]  old_data,
  input  logic [CACHE_LINE_BYTES-1:0] old_mask,
  input  logic [CACHE_LINE_BITS-1:0]  new_data,
  input  logic [CACHE_LINE_BYTES-1:0] new_mask,
  output logic [CACHE_LINE_BITS-1:0]  merged_data_c,
  output logic [CACHE_LINE_BYTES-1:0] merged_mask_c,
  input  store_entry_t                entries [NUM_ENTRIES],
  input  logic [NUM_ENTRIES-1:0]      hit,
  input  logic [IDX_W-1:0]            head,
  output logic [CACHE_LINE_BITS-1:0]  byp_data_c,
  output logic [CACHE_LINE_BYTES-1:0] byp_mask_c
);

  always_comb begin
    merged_data_c = byte_select(new_mask, old_data, new_data);
    merged_mask_c = old_mask | new_mask;
  end

  // Walk oldest to youngest so later (younger) hits overwrite earlier bytes.
  always_comb begin
    byp_data_c = '0;
    byp_mask_c = '0;
    for (int k = 0; k < int'(NUM_ENTRIES); k++) begin
      if (hit[head + IDX_W'(k)]) begin
        byp_mask_c = byp_mask_c | entries[head + IDX_W'(k)].mask;
        byp_data_c = byte_select(entries[head + IDX_W'(k)].mask, byp_data_c,
                                 entries[head + IDX_W'(k)].data);
      end
    end
  end

endmodule

// File: rtl/store_bypass_queue.sv
// Per-strand combining store queue draining to L2, with one-cycle load bypass.
module store_bypass_queue
  import store_bypass_queue_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned ADDR_WIDTH  = 26
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          st_valid_i,
  input  logic [STRAND_INDEX_WIDTH-1:0] st_strand_i,
  input  logic [ADDR_WIDTH-1:0]         st_addr_i,
  input  logic [CACHE_LINE_BITS-1:0]    st_data_i,
  input  logic [CACHE_LINE_BYTES-1:0]   st_mask_i,
  output logic                          st_stall_o,
  input  logic                          ld_valid_i,
  input  logic [STRAND_INDEX_WIDTH-1:0] ld_strand_i,
  input  logic [ADDR_WIDTH-1:0]         ld_addr_i,
  output logic [CACHE_LINE_BYTES-1:0]   byp_mask_o,
  output logic [CACHE_LINE_BITS-1:0]    byp_data_o,
  output logic                          l2_req_valid_o,
  output logic [STRAND_INDEX_WIDTH-1:0] l2_req_strand_o,
  output logic [ADDR_WIDTH-1:0]         l2_req_addr_o,
  output logic [CACHE_LINE_BITS-1:0]    l2_req_data_o,
  output logic [CACHE_LINE_BYTES-1:0]   l2_req_mask_o,
  input  logic                          l2_ack_i,
  output logic                          empty_o
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);

  store_entry_t                entries_q [NUM_ENTRIES];
  store_entry_t                entries_n [NUM_ENTRIES];
  logic [IDX_W-1:0]            head_q, head_n, tail_q, tail_n;
  logic [CNT_W-1:0]            count_q, count_n;
  logic                        full, accept, alloc, deq, merge_hit;
  logic [IDX_W-1:0]            merge_idx;
  logic [NUM_ENTRIES-1:0]      ld_hit;
  logic [ADDR_WIDTH_MAX-1:0]   st_addr_ext, ld_addr_ext;
  logic [CACHE_LINE_BITS-1:0]  merged_data, byp_data_c;
  logic [CACHE_LINE_BYTES-1:0] merged_mask, byp_mask_c;

  assign st_addr_ext = ADDR_WIDTH_MAX'(st_addr_i);
  assign ld_addr_ext = ADDR_WIDTH_MAX'(ld_addr_i);
  assign full        = (count_q == CNT_W'(NUM_ENTRIES));
  assign accept      = st_valid_i && !full;
  assign alloc       = accept && !merge_hit;
  assign deq         = l2_ack_i && entries_q[head_q].valid;

  // Head is already visible to L2, so it is excluded as a merge target.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    ld_hit    = '0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      if (!merge_hit && entries_q[i].valid && (IDX_W'(i) != head_q) &&
          (entries_q[i].strand == st_strand_i) && (entries_q[i].addr == st_addr_ext)) begin
        merge_hit = 1'b1;
        merge_idx = IDX_W'(i);
      end
      ld_hit[i] = ld_valid_i && entries_q[i].valid &&
                  (entries_q[i].strand == ld_strand_i) && (entries_q[i].addr == ld_addr_ext);
    end
  end

  store_byte_merge #(.NUM_ENTRIES(NUM_ENTRIES)) u_merge (
    .old_data      (entries_q[merge_idx].data),
    .old_mask      (entries_q[merge_idx].mask),
    .new_data      (st_data_i),
    .new_mask      (st_mask_i),
    .merged_data_c (merged_data),
    .merged_mask_c (merged_mask),
    .entries       (entries_q),
    .hit           (ld_hit),
    .head          (head_q),
    .byp_data_c    (byp_data_c),
    .byp_mask_c    (byp_mask_c)
  );

  always_comb begin
    entries_n = entries_q;
    head_n    = head_q;
    tail_n    = tail_q;
    if (accept && merge_hit) begin
      entries_n[merge_idx].data = merged_data;
      entries_n[merge_idx].mask = merged_mask;
    end
    if (alloc) begin
      entries_n[tail_q] = '{valid: 1'b1, strand: st_strand_i, addr: st_addr_ext,
                            data: st_data_i, mask: st_mask_i};
      tail_n = tail_q + IDX_W'(1);
    end
    if (deq) begin
      entries_n[head_q].valid = 1'b0;
      head_n = head_q + IDX_W'(1);
    end
    count_n = count_q + CNT_W'(alloc) - CNT_W'(deq);
  end

  // Outputs are registered from next state so they track the queue registers exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) entries_q[i] <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      st_stall_o      <= 1'b0;
      empty_o         <= 1'b1;
      l2_req_valid_o  <= 1'b0;
      l2_req_strand_o <= '0;
      l2_req_addr_o   <= '0;
      l2_req_data_o   <= '0;
      l2_req_mask_o   <= '0;
      byp_mask_o      <= '0;
      byp_data_o      <= '0;
    end else begin
      entries_q       <= entries_n;
      head_q          <= head_n;
      tail_q          <= tail_n;
      count_q         <= count_n;
      st_stall_o      <= (count_n == CNT_W'(NUM_ENTRIES));
      empty_o         <= (count_n == '0);
      l2_req_valid_o  <= entries_n[head_n].valid;
      l2_req_strand_o <= entries_n[head_n].strand;
      l2_req_addr_o   <= entries_n[head_n].addr[ADDR_WIDTH-1:0];
      l2_req_data_o   <= entries_n[head_n].data;
      l2_req_mask_o   <= entries_n[head_n].mask;
      byp_mask_o      <= byp_mask_c;
      byp_data_o      <= byp_data_c;
    end
  end

endmodule

// File: tb/tb_store_bypass_queue.sv
// Directed self-checking bench for store_bypass_queue (NUM_ENTRIES=4, ADDR_WIDTH=26).
module tb_store_bypass_queue;

  logic         clk = 1'b0;
  logic         reset;
  logic         st_valid_i;
  logic [1:0]   st_strand_i;
  logic [25:0]  st_addr_i;
  logic [511:0] st_data_i;
  logic [63:0]  st_mask_i;
  logic         st_stall_o;
  logic         ld_valid_i;
  logic [1:0]   ld_strand_i;
  logic [25:0]  ld_addr_i;
  logic [63:0]  byp_mask_o;
  logic [511:0] byp_data_o;
  logic         l2_req_valid_o;
  logic [1:0]   l2_req_strand_o;
  logic [25:0]  l2_req_addr_o;
  logic [511:0] l2_req_data_o;
  logic [63:0]  l2_req_mask_o;
  logic         l2_ack_i;
  logic         empty_o;

  int errors = 0;
  int checks = 0;

  store_bypass_queue #(.NUM_ENTRIES(4), .ADDR_WIDTH(26)) dut (
    .clk(clk), .reset(reset),
    .st_valid_i(st_valid_i), .st_strand_i(st_strand_i), .st_addr_i(st_addr_i),
    .st_data_i(st_data_i), .st_mask_i(st_mask_i), .st_stall_o(st_stall_o),
    .ld_valid_i(ld_valid_i), .ld_strand_i(ld_strand_i), .ld_addr_i(ld_addr_i),
    .byp_mask_o(byp_mask_o), .byp_data_o(byp_data_o),
    .l2_req_valid_o(l2_req_valid_o), .l2_req_strand_o(l2_req_strand_o),
    .l2_req_addr_o(l2_req_addr_o), .l2_req_data_o(l2_req_data_o),
    .l2_req_mask_o(l2_req_mask_o), .l2_ack_i(l2_ack_i), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  // Line pattern: byte j = seed + j.
  function automatic logic [511:0] pat(input logic [7:0] seed);
    logic [511:0] r;
    for (int j = 0; j < 64; j++) r[j*8 +: 8] = seed + 8'(j);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    st_valid_i = 1'b0; st_strand_i = '0; st_addr_i = '0; st_data_i = '0; st_mask_i = '0;
    ld_valid_i = 1'b0; ld_strand_i = '0; ld_addr_i = '0;
    l2_ack_i   = 1'b0;
  endtask

  task automatic put(input logic [1:0] s, input logic [25:0] a, input logic [511:0] d,
                     input logic [63:0] m);
    st_valid_i = 1'b1; st_strand_i = s; st_addr_i = a; st_data_i = d; st_mask_i = m;
  endtask

  task automatic get(input logic [1:0] s, input logic [25:0] a);
    ld_valid_i = 1'b1; ld_strand_i = s; ld_addr_i = a;
  endtask

  task automatic do_reset();
    reset = 1'b1; idle(); step(); step(); reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0h exp=1", empty_o); end
    checks++; if (st_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0h exp=0", st_stall_o); end
    checks++; if (l2_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_l2_valid got=%0h exp=0", l2_req_valid_o); end
    checks++; if (byp_mask_o !== 64'h0) begin errors++; $display("FAIL reset_byp_mask got=%0h exp=0", byp_mask_o); end
    checks++; if (l2_req_addr_o !== 26'h0) begin errors++; $display("FAIL reset_l2_addr got=%0h exp=0", l2_req_addr_o); end
  endtask

  task automatic test_basic_bypass();
    logic [511:0] a, exp;
    do_reset();
    a = pat(8'h10);
    put(2'd0, 26'h10, a, 64'h000F); step(); idle();
    checks++; if (l2_req_valid_o !== 1'b1) begin errors++; $display("FAIL basic_l2_valid got=%0h exp=1", l2_req_valid_o); end
    checks++; if (l2_req_addr_o !== 26'h10) begin errors++; $display("FAIL basic_l2_addr got=%0h exp=10", l2_req_addr_o); end
    checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL basic_empty got=%0h exp=0", empty_o); end
    get(2'd0, 26'h10); step(); idle();
    exp = '0; exp[31:0] = a[31:0];
    checks++; if (byp_mask_o !== 64'h000F) begin errors++; $display("FAIL basic_byp_mask got=%0h exp=f", byp_mask_o); end
    checks++; if (byp_data_o !== exp) begin errors++; $display("FAIL basic_byp_data got=%0h exp=%0h", byp_data_o, exp); end
    step();
    checks++; if (byp_mask_o !== 64'h0 || byp_data_o !== 512'h0) begin errors++; $display("FAIL basic_no_load got=%0h exp=0", byp_mask_o); end
    l2_ack_i = 1'b1; step();
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL basic_drain_empty got=%0h exp=1", empty_o); end
    put(2'd0, 26'h11, a, 64'h1); step(); idle();
    checks++; if (l2_req_addr_o !== 26'h11 || empty_o !== 1'b0) begin errors++; $display("FAIL basic_ack_empty_ignored got=%0h exp=11", l2_req_addr_o); end
  endtask

  task automatic test_merge();
    logic [511:0] a, b, c, d, e, f, exp;
    do_reset();
    a = pat(8'h40); b = pat(8'h50); c = pat(8'h60); d = pat(8'h70); e = pat(8'h80); f = pat(8'h90);
    put(2'd1, 26'h10, a, 64'h000F); step();
    put(2'd1, 26'h20, b, 64'h000F); step();
    put(2'd1, 26'h10, c, 64'h00F0); step();
    checks++; if (l2_req_mask_o !== 64'h000F) begin errors++; $display("FAIL merge_head_untouched got=%0h exp=f", l2_req_mask_o); end
    put(2'd1, 26'h20, d, 64'hFF00); step();
    put(2'd1, 26'h10, e, 64'h0101); step(); idle();
    checks++; if (st_stall_o !== 1'b0) begin errors++; $display("FAIL merge_count3_stall got=%0h exp=0", st_stall_o); end
    checks++; if (l2_req_data_o !== a || l2_req_mask_o !== 64'h000F) begin errors++; $display("FAIL merge_head_stable got=%0h exp=f", l2_req_mask_o); end
    get(2'd1, 26'h10); step(); idle();
    exp = '0; exp[7:0] = e[7:0]; exp[31:8] = a[31:8]; exp[63:32] = c[63:32]; exp[71:64] = e[71:64];
    checks++; if (byp_mask_o !== 64'h01FF) begin errors++; $display("FAIL merge_byp10_mask got=%0h exp=1ff", byp_mask_o); end
    checks++; if (byp_data_o !== exp) begin errors++; $display("FAIL merge_byp10_data got=%0h exp=%0h", byp_data_o, exp); end
    get(2'd1, 26'h20); step(); idle();
    exp = '0; exp[31:0] = b[31:0]; exp[127:64] = d[127:64];
    checks++; if (byp_mask_o !== 64'hFF0F) begin errors++; $display("FAIL merge_byp20_mask got=%0h exp=ff0f", byp_mask_o); end
    checks++; if (byp_data_o !== exp) begin errors++; $display("FAIL merge_byp20_data got=%0h exp=%0h", byp_data_o, exp); end
    put(2'd1, 26'h40, f, 64'h1); step(); idle();
    checks++; if (st_stall_o !== 1'b1) begin errors++; $display("FAIL merge_full_stall got=%0h exp=1", st_stall_o); end
    checks++; if (l2_req_addr_o !== 26'h10) begin errors++; $display("FAIL merge_drain0 got=%0h exp=10", l2_req_addr_o); end
    l2_ack_i = 1'b1; step();
    checks++; if (l2_req_addr_o !== 26'h20 || l2_req_mask_o !== 64'hFF0F) begin errors++; $display("FAIL merge_drain1 got=%0h/%0h exp=20/ff0f", l2_req_addr_o, l2_req_mask_o); end
    step();
    checks++; if (l2_req_addr_o !== 26'h10 || l2_req_mask_o !== 64'h01F1) begin errors++; $display("FAIL merge_drain2 got=%0h/%0h exp=10/1f1", l2_req_addr_o, l2_req_mask_o); end
    step();
    checks++; if (l2_req_addr_o !== 26'h40) begin errors++; $display("FAIL merge_drain3 got=%0h exp=40", l2_req_addr_o); end
    step(); idle();
    checks++; if (empty_o !== 1'b1 || l2_req_valid_o !== 1'b0) begin errors++; $display("FAIL merge_drained got=%0h/%0h exp=1/0", empty_o, l2_req_valid_o); end
  endtask

  task automatic test_full_stall();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      put(2'd0, 26'h100 + 26'(k), pat(8'(k)), 64'hFFFF_FFFF_FFFF_FFFF); step();
    end
    checks++; if (st_stall_o !== 1'b1) begin errors++; $display("FAIL full_stall got=%0h exp=1", st_stall_o); end
    put(2'd0, 26'h104, pat(8'h4), 64'h1); step();
    checks++; if (st_stall_o !== 1'b1 || l2_req_addr_o !== 26'h100) begin errors++; $display("FAIL full_held got=%0h/%0h exp=1/100", st_stall_o, l2_req_addr_o); end
    l2_ack_i = 1'b1; step(); l2_ack_i = 1'b0;
    checks++; if (st_stall_o !== 1'b0 || l2_req_addr_o !== 26'h101) begin errors++; $display("FAIL full_ack_drop got=%0h/%0h exp=0/101", st_stall_o, l2_req_addr_o); end
    step(); idle();
    checks++; if (st_stall_o !== 1'b1) begin errors++; $display("FAIL full_fifth_accepted got=%0h exp=1", st_stall_o); end
    l2_ack_i = 1'b1; step();
    put(2'd0, 26'h105, pat(8'h5), 64'h1); step(); idle();
    checks++; if (st_stall_o !== 1'b0 || l2_req_addr_o !== 26'h103) begin errors++; $display("FAIL full_alloc_deq got=%0h/%0h exp=0/103", st_stall_o, l2_req_addr_o); end
    put(2'd0, 26'h106, pat(8'h6), 64'h1); step(); idle();
    checks++; if (st_stall_o !== 1'b1) begin errors++; $display("FAIL full_refill got=%0h exp=1", st_stall_o); end
    l2_ack_i = 1'b1;
    for (int k = 4; k < 7; k++) begin
      step();
      checks++; if (l2_req_addr_o !== 26'h100 + 26'(k)) begin errors++; $display("FAIL full_order%0d got=%0h exp=%0h", k, l2_req_addr_o, 26'h100 + 26'(k)); end
    end
    step(); idle();
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL full_drained got=%0h exp=1", empty_o); end
  endtask

  task automatic test_same_cycle();
    logic [511:0] g, exp;
    do_reset();
    g = pat(8'hC0);
    put(2'd0, 26'h30, g, 64'h00FF); get(2'd0, 26'h30); step(); idle();
    checks++; if (byp_mask_o !== 64'h0 || byp_data_o !== 512'h0) begin errors++; $display("FAIL same_cycle_invisible got=%0h exp=0", byp_mask_o); end
    exp = '0; exp[63:0] = g[63:0];
    get(2'd0, 26'h30); step();
    checks++; if (byp_mask_o !== 64'h00FF || byp_data_o !== exp) begin errors++; $display("FAIL same_cycle_repeat got=%0h exp=ff", byp_mask_o); end
    l2_ack_i = 1'b1; step(); l2_ack_i = 1'b0;
    checks++; if (byp_mask_o !== 64'h00FF || empty_o !== 1'b1) begin errors++; $display("FAIL deq_still_visible got=%0h/%0h exp=ff/1", byp_mask_o, empty_o); end
    step(); idle();
    checks++; if (byp_mask_o !== 64'h0) begin errors++; $display("FAIL after_deq_gone got=%0h exp=0", byp_mask_o); end
  endtask

  task automatic test_strand_reset();
    do_reset();
    put(2'd0, 26'h50, pat(8'hE0), 64'h000F); step(); idle();
    get(2'd2, 26'h50); step(); idle();
    checks++; if (byp_mask_o !== 64'h0) begin errors++; $display("FAIL other_strand got=%0h exp=0", byp_mask_o); end
    checks++; if (l2_req_valid_o !== 1'b1) begin errors++; $display("FAIL pre_reset_l2_valid got=%0h exp=1", l2_req_valid_o); end
    reset = 1'b1; put(2'd0, 26'h60, pat(8'h1), 64'h1); get(2'd0, 26'h50); step();
    checks++; if (l2_req_valid_o !== 1'b0 || empty_o !== 1'b1) begin errors++; $display("FAIL mid_reset got=%0h/%0h exp=0/1", l2_req_valid_o, empty_o); end
    checks++; if (byp_mask_o !== 64'h0 || st_stall_o !== 1'b0) begin errors++; $display("FAIL mid_reset_byp got=%0h exp=0", byp_mask_o); end
    reset = 1'b0; idle(); step();
    checks++; if (empty_o !== 1'b1 || l2_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_store_ignored got=%0h/%0h exp=1/0", empty_o, l2_req_valid_o); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_basic_bypass();
    test_merge();
    test_full_stall();
    test_same_cycle();
    test_strand_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_bypass_queue.md
STORE_BYPASS_QUEUE -- requirements
Module: store_bypass_queue

Interface
REQ-001 Parameter NUM_ENTRIES, default 4, pending-store slots; SHALL be a power of 2 in 2..8.
REQ-002 Parameter ADDR_WIDTH, default 26, cache-line address bits.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 st_valid_i  input  1  store request.
REQ-007 st_strand_i  input  2  issuing strand.
REQ-008 st_addr_i  input  ADDR_WIDTH  store line address.
REQ-009 st_data_i  input  512  store line data.
REQ-010 st_mask_i  input  64  store byte enables.
REQ-011 st_stall_o  output  1  queue full; store not accepted.
REQ-012 ld_valid_i  input  1  load lookup request.
REQ-013 ld_strand_i  input  2  loading strand.
REQ-014 ld_addr_i  input  ADDR_WIDTH  load line address.
REQ-015 byp_mask_o  output  64  per-byte bypass select (1 = take byp_data_o byte).
REQ-016 byp_data_o  output  512  bypass data.
REQ-017 l2_req_valid_o  output  1  drain request to L2.
REQ-018 l2_req_strand_o / l2_req_addr_o / l2_req_data_o / l2_req_mask_o  output  2 / ADDR_WIDTH / 512 / 64  head-entry fields.
REQ-019 l2_ack_i  input  1  L2 accepted head entry.
REQ-020 empty_o  output  1  no valid entries.

Function
REQ-021 Entries SHALL be held in FIFO order: head/tail pointers wrap modulo NUM_ENTRIES; count register 0..NUM_ENTRIES.
REQ-022 st_stall_o SHALL equal (count == NUM_ENTRIES) from registered state only; a store presented while full is not accepted, even if combinable.
REQ-023 Accepted store (st_valid_i & !st_stall_o): if a valid non-head entry matches strand and address, merge -- bytes with st_mask_i=1 overwrite data, mask |= st_mask_i, count unchanged; otherwise allocate at tail, count+1.
REQ-024 The head entry SHALL never be a merge target (it is visible to L2).
REQ-025 l2_req_valid_o SHALL be 1 whenever head entry valid; all l2_req_* fields stable until l2_ack_i.
REQ-026 l2_ack_i with l2_req_valid_o SHALL dequeue head next edge; l2_ack_i while l2_req_valid_o=0 SHALL be ignored.
REQ-027 Simultaneous allocate and dequeue SHALL leave count unchanged and advance both pointers.
REQ-028 Bypass latency SHALL be one cycle: lookup in cycle N uses state before cycle-N updates (store accepted in N invisible; entry dequeued in N still visible); result registered in byp_* at N+1.
REQ-029 Per byte, byp_data_o SHALL come from the youngest valid entry with matching strand, address and mask bit set; byp_mask_o = OR of matching masks; no match gives byte mask 0, data 0.
REQ-030 ld_valid_i=0 in cycle N SHALL give byp_mask_o=0, byp_data_o=0 at N+1.
REQ-031 Loads from other strands SHALL never receive bypass data.
REQ-032 empty_o SHALL equal (count == 0).

Reset
REQ-033 Reset SHALL clear all valid bits, pointers and count; next cycle all outputs 0 except empty_o=1.
REQ-034 Reset mid-drain SHALL abandon the head request; stores/loads presented during reset SHALL be ignored.

Structure
REQ-035 Shared package SHALL hold CACHE_LINE_BYTES=64, CACHE_LINE_BITS=512, STRAND_INDEX_WIDTH=2 and the store-entry typedef (valid, strand, addr, data, mask).
REQ-036 Byte-granular merge (combine and bypass priority) SHALL be a sub-module store_byte_merge.

Verification
REQ-037 Store strand0 addr 0x10 mask 0x000F, then load strand0 0x10 -> next cycle byp_mask_o=0x000F, bytes 0-3 equal stored data.
REQ-038 Stores addr 0x10,0x20,0x10 (mask 0x00F0) strand1, no ack -> third merges into 0x20-free entry count=2? No: first 0x10 is head, so count=3; fourth store 0x20 mask 0xFF00 merges, count stays 3.
REQ-039 Four distinct stores, NUM_ENTRIES=4 -> st_stall_o=1; fifth held; l2_ack_i one cycle -> stall drops, fifth accepted, l2_req_addr_o shows second store.
REQ-040 Same-cycle store and load to 0x30 on empty queue -> byp_mask_o=0 next cycle; repeat load -> mask matches store.
REQ-041 Load strand2 to address pending for strand0 -> byp_mask_o=0; reset asserted with l2_req_valid_o=1 -> next cycle l2_req_valid_o=0, empty_o=1.
